// File: rtl/pe_array_os_ctrl_if.sv
// Job, operand and result-drain signals of the output-stationary MAC array.
// The master side is the sequencer/testbench; the slave side is the array.
interface pe_array_os_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int K_WIDTH    = 16
);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic                       start;
   logic [K_WIDTH-1:0]         k_len;
   logic                       signed_mode;
   logic                       in_valid;
   logic                       in_ready;
   logic [ROWS*DATA_WIDTH-1:0] a_in;
   logic [COLS*DATA_WIDTH-1:0] b_in;
   logic                       out_valid;
   logic                       out_ready;
   logic [COLS*ACC_WIDTH-1:0]  out_data;
   logic [ROW_W-1:0]           out_row;
   logic                       busy;
   logic                       done;

   modport master (
      output start, k_len, signed_mode, in_valid, a_in, b_in, out_ready,
      input  in_ready, out_valid, out_data, out_row, busy, done
   );

   modport slave (
      input  start, k_len, signed_mode, in_valid, a_in, b_in, out_ready,
      output in_ready, out_valid, out_data, out_row, busy, done
   );
endinterface

// File: rtl/pe_array_os_ctrl.sv
// Output-stationary ROWS x COLS MAC array with internal operand skew and a
// load -> flush -> drain job sequencer presenting one accumulator row per beat.
module pe_array_os_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int K_WIDTH    = 16
) (
   input logic              clk,
   input logic              rst,
   pe_array_os_ctrl_if.slave bus
);
   localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int FLUSH_LEN = ROWS + COLS - 1;
   localparam int FLUSH_W   = $clog2(FLUSH_LEN + 1);

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;
   typedef struct packed {
      logic                  vld;
      logic [DATA_WIDTH-1:0] dat;
   } opnd_t;

   state_e                   state_q, state_d;
   logic [K_WIDTH-1:0]       cnt_q, cnt_d, klen_q, klen_d;
   logic                     sgn_q, sgn_d;
   logic [FLUSH_W-1:0]       flush_q, flush_d;
   logic [ROW_W-1:0]         row_q, row_d, sel_row;
   logic [COLS*ACC_WIDTH-1:0] data_q, data_d, sel_data;
   logic                     done_q, done_d;
   logic                     accept, clear;

   opnd_t                    a_edge [ROWS];
   opnd_t                    b_edge [COLS];
   opnd_t                    a_in_w [ROWS][COLS];
   opnd_t                    b_in_w [ROWS][COLS];
   opnd_t                    a_pe_q [ROWS][COLS];
   opnd_t                    b_pe_q [ROWS][COLS];
   logic [ACC_WIDTH-1:0]     acc_q  [ROWS][COLS];

   // Exact product in 2*DATA_WIDTH+2 signed bits; both modes then fit, and the
   // cast sign-extends (or wraps) it to the accumulator width.
   function automatic logic [ACC_WIDTH-1:0] mac_term(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b,
                                                     input logic               sgn);
      logic signed [2*DATA_WIDTH+1:0] ax, bx, p;
      ax = {{(DATA_WIDTH+2){sgn & a[DATA_WIDTH-1]}}, a};
      bx = {{(DATA_WIDTH+2){sgn & b[DATA_WIDTH-1]}}, b};
      p  = ax * bx;
      return ACC_WIDTH'(p);
   endfunction

   assign accept = bus.in_valid && (state_q == LOAD);

   for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
      opnd_t sk_q [r+1];
      always_ff @(posedge clk) begin
         if (rst || clear) begin
            for (int i = 0; i <= r; i++) sk_q[i] <= '0;
         end else begin
            sk_q[0] <= accept ? {1'b1, bus.a_in[r*DATA_WIDTH +: DATA_WIDTH]} : '0;
            for (int i = 1; i <= r; i++) sk_q[i] <= sk_q[i-1];
         end
      end
      assign a_edge[r] = sk_q[r];
   end

   for (genvar c = 0; c < COLS; c++) begin : g_b_skew
      opnd_t sk_q [c+1];
      always_ff @(posedge clk) begin
         if (rst || clear) begin
            for (int i = 0; i <= c; i++) sk_q[i] <= '0;
         end else begin
            sk_q[0] <= accept ? {1'b1, bus.b_in[c*DATA_WIDTH +: DATA_WIDTH]} : '0;
            for (int i = 1; i <= c; i++) sk_q[i] <= sk_q[i-1];
         end
      end
      assign b_edge[c] = sk_q[c];
   end

   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            a_in_w[r][c] = (c == 0) ? a_edge[r] : a_pe_q[r][(c == 0) ? 0 : c - 1];
            b_in_w[r][c] = (r == 0) ? b_edge[c] : b_pe_q[(r == 0) ? 0 : r - 1][c];
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: accumulators are cleared like any other register; a stale sum would leak into the next job.
      if (rst || clear) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               a_pe_q[r][c] <= '0;
               b_pe_q[r][c] <= '0;
               acc_q[r][c]  <= '0;
            end
         end
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               a_pe_q[r][c] <= a_in_w[r][c];
               b_pe_q[r][c] <= b_in_w[r][c];
               if (a_in_w[r][c].vld && b_in_w[r][c].vld)
                  acc_q[r][c] <= acc_q[r][c] +
                                 mac_term(a_in_w[r][c].dat, b_in_w[r][c].dat, sgn_q);
            end
         end
      end
   end

   // Row to load into the output register: row 0 on entry to DRAIN, else the next row.
   always_comb begin
      sel_row  = '0;
      sel_data = '0;
      if (state_q == DRAIN && row_q != ROW_W'(ROWS - 1)) sel_row = row_q + ROW_W'(1);
      for (int c = 0; c < COLS; c++) sel_data[c*ACC_WIDTH +: ACC_WIDTH] = acc_q[sel_row][c];
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      klen_d  = klen_q;
      sgn_d   = sgn_q;
      flush_d = flush_q;
      row_d   = row_q;
      data_d  = data_q;
      done_d  = 1'b0;
      clear   = 1'b0;
      unique case (state_q)
         IDLE: if (bus.start) begin
            klen_d = bus.k_len;
            sgn_d  = bus.signed_mode;
            cnt_d  = '0;
            row_d  = '0;
            if (bus.k_len == '0) begin
               state_d = DRAIN;
               data_d  = sel_data;
            end else begin
               state_d = LOAD;
            end
         end
         LOAD: if (accept) begin
            cnt_d = cnt_q + K_WIDTH'(1);
            if (cnt_d == klen_q) begin
               state_d = FLUSH;
               flush_d = '0;
            end
         end
         FLUSH: begin
            flush_d = flush_q + FLUSH_W'(1);
            if (flush_q == FLUSH_W'(FLUSH_LEN - 1)) begin
               state_d = DRAIN;
               row_d   = '0;
               data_d  = sel_data;
            end
         end
         DRAIN: if (bus.out_ready) begin
            if (row_q == ROW_W'(ROWS - 1)) begin
               state_d = IDLE;
               clear   = 1'b1;
               done_d  = 1'b1;
               row_d   = '0;
               data_d  = '0;
            end else begin
               row_d  = sel_row;
               data_d = sel_data;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         klen_q  <= '0;
         sgn_q   <= 1'b0;
         flush_q <= '0;
         row_q   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         klen_q  <= klen_d;
         sgn_q   <= sgn_d;
         flush_q <= flush_d;
         row_q   <= row_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign bus.in_ready  = (state_q == LOAD);
   assign bus.out_valid = (state_q == DRAIN);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_data  = data_q;
   assign bus.out_row   = row_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_pe_array_os_ctrl.sv
// Self-checking bench: table of jobs with a row scoreboard, plus reset-abort,
// k_len=0 and a 16-bit-accumulator instance for wrap-around.
module tb_pe_array_os_ctrl;
   localparam int DW = 8, ROWS = 4, COLS = 4, AW = 32, AWS = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pe_array_os_ctrl_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW),  .ROWS(ROWS), .COLS(COLS)) m_if ();
   pe_array_os_ctrl_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AWS), .ROWS(ROWS), .COLS(COLS)) s_if ();

   pe_array_os_ctrl #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(ROWS), .COLS(COLS))
      u_dut (.clk(clk), .rst(rst), .bus(m_if));
   pe_array_os_ctrl #(.DATA_WIDTH(DW), .ACC_WIDTH(AWS), .ROWS(ROWS), .COLS(COLS))
      u_dut16 (.clk(clk), .rst(rst), .bus(s_if));

   typedef struct {
      int                   k;
      bit                   sgn;
      bit                   bub;
      bit                   poke;
      int                   stall;
      logic [ROWS*DW-1:0]   a;
      logic [COLS*DW-1:0]   b;
      int                   lat;
      logic [AW-1:0]        corner;
   } vec_t;

   typedef struct {
      int                   row;
      logic [COLS*AW-1:0]   data;
   } beat_t;

   beat_t sb [$];
   vec_t  tbl [7];
   int    checks = 0, errors = 0, done_cnt = 0, jobs_done = 0;

   always @(negedge clk) if (m_if.done === 1'b1) done_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [COLS*AW-1:0] got,
                        input logic [COLS*AW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] model(input int k, input bit sgn,
                                           input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint pa, pb;
      pa = sgn ? longint'($signed(a)) : longint'(a);
      pb = sgn ? longint'($signed(b)) : longint'(b);
      return AW'(longint'(k) * pa * pb);
   endfunction

   task automatic push_job(input vec_t v);
      beat_t bt;
      for (int r = 0; r < ROWS; r++) begin
         bt.row  = r;
         bt.data = '0;
         for (int c = 0; c < COLS; c++)
            bt.data[c*AW +: AW] = model(v.k, v.sgn, v.a[r*DW +: DW], v.b[c*DW +: DW]);
         sb.push_back(bt);
      end
   endtask

   task automatic feed(input vec_t v);
      int n = 0, guard = 0;
      bit tog = 1'b1, acc;
      m_if.start       = 1'b1;
      m_if.k_len       = 16'(v.k);
      m_if.signed_mode = v.sgn;
      tick();
      m_if.start = 1'b0;
      while (n < v.k && guard < 200) begin
         guard++;
         m_if.in_valid = v.bub ? tog : 1'b1;
         tog = ~tog;
         if (m_if.in_valid) begin
            m_if.a_in = v.a;
            m_if.b_in = v.b;
         end else begin
            m_if.a_in = $urandom;
            m_if.b_in = $urandom;
         end
         if (v.poke && n == 1) begin
            m_if.start = 1'b1;
            m_if.k_len = '0;
         end
         acc = m_if.in_valid && m_if.in_ready;
         tick();
         m_if.start = 1'b0;
         m_if.k_len = 16'(v.k);
         if (acc) n++;
      end
      m_if.in_valid = 1'b0;
      checks++;
      if (n != v.k) begin
         errors++;
         $display("FAIL feed_accepts: got %0d expected %0d", n, v.k);
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!m_if.out_valid && lat < 64) begin
         tick();
         lat++;
      end
   endtask

   task automatic drain(input int stall_row, input int stall_len,
                        output logic [COLS*AW-1:0] last);
      int beats = 0, guard = 0, stalled = 0, held_row = 0;
      logic [COLS*AW-1:0] held = '0;
      beat_t eb;
      last = '0;
      while (beats < ROWS && guard < 200) begin
         guard++;
         if (!m_if.out_valid) begin
            m_if.out_ready = 1'b1;
            tick();
         end else if (int'(m_if.out_row) == stall_row && stalled < stall_len) begin
            m_if.out_ready = 1'b0;
            if (stalled == 0) begin
               held     = m_if.out_data;
               held_row = int'(m_if.out_row);
            end else begin
               check("stall_data", m_if.out_data, held);
               check("stall_row", m_if.out_row, held_row);
            end
            stalled++;
            tick();
         end else begin
            m_if.out_ready = 1'b1;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_empty: got beat row %0d expected none", m_if.out_row);
               break;
            end
            eb = sb.pop_front();
            check($sformatf("beat_row%0d", eb.row), m_if.out_row, eb.row);
            check($sformatf("beat_data%0d", eb.row), m_if.out_data, eb.data);
            if (beats == ROWS - 1) last = m_if.out_data;
            tick();
            beats++;
         end
      end
      m_if.out_ready = 1'b0;
      if (beats < ROWS) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d beats expected %0d", beats, ROWS);
      end
      check("done_pulse", m_if.done, 1'b1);
      check("valid_drop", m_if.out_valid, 1'b0);
      jobs_done++;
   endtask

   initial begin
      int lat;
      logic [COLS*AW-1:0]  last;
      logic [COLS*AWS-1:0] exp16;
      vec_t v;

      //        k  sgn   bub   poke  stall a             b             lat corner
      tbl[0] = '{1, 1'b0, 1'b0, 1'b0, 0, 32'h04030201, 32'h01010101, 8, 32'd4};
      tbl[1] = '{3, 1'b1, 1'b0, 1'b0, 0, 32'hFFFFFFFF, 32'h02020202, 8, 32'hFFFFFFFA};
      tbl[2] = '{3, 1'b0, 1'b0, 1'b0, 0, 32'hFFFFFFFF, 32'h02020202, 8, 32'd1530};
      tbl[3] = '{4, 1'b0, 1'b1, 1'b0, 0, 32'h04030201, 32'h08070605, 8, 32'd128};
      tbl[4] = '{4, 1'b0, 1'b0, 1'b0, 5, 32'h04030201, 32'h08070605, 8, 32'd128};
      tbl[5] = '{2, 1'b1, 1'b1, 1'b1, 0, 32'hFE017F80, 32'h02FF7F80, 8, 32'hFFFFFFF8};
      tbl[6] = '{0, 1'b0, 1'b0, 1'b0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'd0};

      rst = 1'b1;
      m_if.start = 1'b0; m_if.k_len = '0; m_if.signed_mode = 1'b0; m_if.in_valid = 1'b0;
      m_if.a_in = '0; m_if.b_in = '0; m_if.out_ready = 1'b0;
      s_if.start = 1'b0; s_if.k_len = '0; s_if.signed_mode = 1'b0; s_if.in_valid = 1'b0;
      s_if.a_in = '0; s_if.b_in = '0; s_if.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", m_if.in_ready, 1'b0);
      check("rst_out_valid", m_if.out_valid, 1'b0);
      check("rst_out_data", m_if.out_data, '0);
      check("rst_out_row", m_if.out_row, '0);
      check("rst_busy", m_if.busy, 1'b0);
      check("rst_done", m_if.done, 1'b0);

      // Each job starts in the done cycle of the previous one (back-to-back).
      for (int i = 0; i < 7; i++) begin
         push_job(tbl[i]);
         feed(tbl[i]);
         check($sformatf("in_ready_after_load%0d", i), m_if.in_ready, 1'b0);
         check($sformatf("busy_after_load%0d", i), m_if.busy, 1'b1);
         wait_valid(lat);
         check($sformatf("latency%0d", i), lat, tbl[i].lat);
         drain(1, tbl[i].stall, last);
         check($sformatf("corner%0d", i), last[(COLS-1)*AW +: AW], tbl[i].corner);
      end

      // Abort a job with reset while operands are still in flight.
      v = '{2, 1'b1, 1'b0, 1'b0, 0, 32'h80808080, 32'h7F7F7F7F, 8, 32'd0};
      feed(v);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_in_ready", m_if.in_ready, 1'b0);
      check("abort_out_valid", m_if.out_valid, 1'b0);
      check("abort_out_data", m_if.out_data, '0);
      check("abort_out_row", m_if.out_row, '0);
      check("abort_busy", m_if.busy, 1'b0);
      check("abort_done", m_if.done, 1'b0);

      v = '{1, 1'b0, 1'b0, 1'b0, 0, 32'h01010101, 32'h01010101, 8, 32'd1};
      push_job(v);
      feed(v);
      wait_valid(lat);
      check("latency_after_abort", lat, 8);
      drain(1, 0, last);
      check("corner_after_abort", last[(COLS-1)*AW +: AW], 32'd1);
      tick();
      check("done_count", done_cnt, jobs_done);

      // 16-bit accumulators: 2 * 255 * 255 wraps modulo 2^16.
      exp16 = '0;
      for (int c = 0; c < COLS; c++) exp16[c*AWS +: AWS] = 16'(2 * 255 * 255);
      s_if.start = 1'b1;
      s_if.k_len = 16'd2;
      s_if.signed_mode = 1'b0;
      tick();
      s_if.start = 1'b0;
      s_if.in_valid = 1'b1;
      s_if.a_in = 32'hFFFFFFFF;
      s_if.b_in = 32'hFFFFFFFF;
      tick();
      tick();
      s_if.in_valid = 1'b0;
      lat = 1;
      while (!s_if.out_valid && lat < 64) begin
         tick();
         lat++;
      end
      check("acc16_latency", lat, 8);
      for (int r = 0; r < ROWS; r++) begin
         s_if.out_ready = 1'b1;
         check($sformatf("acc16_row%0d", r), s_if.out_row, r);
         check($sformatf("acc16_data%0d", r), s_if.out_data, exp16);
         tick();
      end
      s_if.out_ready = 1'b0;
      check("acc16_done", s_if.done, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
